macc_accum_requant: RTL and testbench

- Sits directly downstream of the multiply-accumulate stage (8x8 multipliers plus adder tree).
- Takes the MACC partial-sum stream and accumulates NUM_PASSES consecutive partial sums into one output-neuron sum, so kernels larger than the MACC width can be processed.
- Adds a bias, applies a rounding arithmetic right shift and optional ReLU, then saturates to signed int8 for the next layer's input buffer.
- There is no backpressure; the upstream stage produces a valid pulse stream.

---
 rtl/macc_accum_requant.sv | 135 +++++++++++++
 tb/tb_macc_accum_requant.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_accum_requant.sv
// Partial-sum accumulator with bias, rounding shift, optional ReLU
// and int8 saturation, sitting behind the MACC adder tree.
module macc_accum_requant #(
  parameter int IN_WIDTH    = 21,
  parameter int NUM_PASSES  = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_WIDTH-1:0]    i_data,
  input  logic                   i_valid,
  input  logic [ACC_WIDTH-1:0]   i_bias,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic                   i_relu_en,
  input  logic                   i_flush,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  output logic                   o_busy
);

  localparam int CW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_PASSES - 1);
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] PMAX = RW'(127);
  localparam logic signed [RW-1:0] NMIN = RW'(-128);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   relu_q, relu_d;
  logic [ACC_WIDTH-1:0]   res_q, res_d;
  logic [SHIFT_WIDTH-1:0] sha_q, sha_d;
  logic                   rla_q, rla_d;
  logic                   va_q, va_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   first, last;
  logic [ACC_WIDTH-1:0]   x, base, sum_in;

  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == LAST);
  assign x      = ACC_WIDTH'($signed(i_data));
  assign base   = first ? i_bias : acc_q;
  assign sum_in = base + x;

  // Accumulation and stage A
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    res_d   = res_q;
    sha_d   = sha_q;
    rla_d   = rla_q;
    va_d    = 1'b0;
    if (i_flush) begin
      cnt_d = '0;
    end else if (i_valid) begin
      if (first) begin
        shift_d = i_shift;
        relu_d  = i_relu_en;
      end
      if (last) begin
        cnt_d = '0;
        res_d = sum_in;
        sha_d = first ? i_shift : shift_q;
        rla_d = first ? i_relu_en : relu_q;
        va_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = sum_in;
      end
    end
  end

  logic signed [RW-1:0] ext, rnd, rsum, r;
  logic [7:0]           sat;

  // Stage B: one extra bit keeps the rounding add from overflowing
  always_comb begin
    ext  = {res_q[ACC_WIDTH-1], res_q};
    rnd  = (sha_q == '0) ? '0 : (RW'(1) << (sha_q - 1'b1));
    rsum = ext + rnd;
    r    = rsum >>> sha_q;
    if (rla_q && r[RW-1]) begin
      r = '0;
    end
    if (r > PMAX) begin
      sat = 8'h7f;
    end else if (r < NMIN) begin
      sat = 8'h80;
    end else begin
      sat = r[7:0];
    end
    valid_d = va_q & ~i_flush;
    data_d  = valid_d ? sat : data_q;
    busy_d  = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      res_q   <= '0;
      sha_q   <= '0;
      rla_q   <= 1'b0;
      va_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      relu_q  <= relu_d;
      res_q   <= res_d;
      sha_q   <= sha_d;
      rla_q   <= rla_d;
      va_q    <= va_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_macc_accum_requant.sv
// Scoreboard bench for macc_accum_requant: expected int8 results
// are queued when a group's last beat is driven.
module tb_macc_accum_requant;

  localparam int IW = 21;
  localparam int AW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic [AW-1:0] i_bias = '0;
  logic [SW-1:0] i_shift = '0;
  logic          i_relu_en = 1'b0;
  logic          i_flush = 1'b0;
  logic [7:0]    o_data;
  logic          o_valid;
  logic          o_busy;

  int vectors = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  macc_accum_requant #(
    .IN_WIDTH(IW), .NUM_PASSES(4),
    .ACC_WIDTH(AW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_valid(i_valid),
    .i_bias(i_bias), .i_shift(i_shift),
    .i_relu_en(i_relu_en), .i_flush(i_flush),
    .o_data(o_data), .o_valid(o_valid),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: every output pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: got o_valid=1 o_data=%0d, required no output",
                 $signed(o_data));
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          errors++;
          $display("FAIL result: got %0d, required %0d",
                   $signed(o_data), $signed(e));
        end
      end
    end
  end

  function automatic logic [7:0] model(input longint s, input int sh,
                                       input bit relu);
    longint r;
    if (sh == 0) r = s;
    else r = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic beat(input int d, input int b, input int s, input bit rl);
    i_valid   = 1'b1;
    i_data    = IW'(d);
    i_bias    = AW'(b);
    i_shift   = SW'(s);
    i_relu_en = rl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_flush = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results missing, required 0",
               name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({o_data, o_valid, o_busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h valid=%b busy=%b, required 0/0/0",
               o_data, o_valid, o_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    int d[4] = '{100, 200, -50, 30};
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        if (c == 3) exp_q.push_back(8'd75);
        i_valid = 1'b1; i_data = IW'(d[c]);
        i_bias = AW'(20); i_shift = 5'd2; i_relu_en = 1'b0;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (o_busy !== (c >= 1 && c <= 3)) begin
        errors++;
        $display("FAIL basic_busy c%0d: got %b, required %b",
                 c, o_busy, (c >= 1 && c <= 3));
      end
      vectors++;
      if (o_valid !== (c == 5)) begin
        errors++;
        $display("FAIL basic_valid c%0d: got %b, required %b",
                 c, o_valid, (c == 5));
      end
      @(posedge clk); #1;
    end
    idle(2);
    check_drained("basic");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(8'd127);
      beat(1000, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(8'h80);
      beat(-100, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(8'h00);
      beat(-100, 0, 0, 1);
    end
    idle(4);
    check_drained("saturation");
  endtask

  task automatic test_rounding;
    int sums[3] = '{-6, -7, 6};
    logic [7:0] exps[3] = '{8'hff, 8'hfe, 8'h02};
    for (int g = 0; g < 3; g++) begin
      beat(sums[g], 0, 2, 0);
      beat(0, 0, 2, 0);
      beat(0, 0, 2, 0);
      exp_q.push_back(exps[g]);
      beat(0, 0, 2, 0);
    end
    idle(4);
    check_drained("rounding");
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        if (c == 3 || c == 7) exp_q.push_back(8'd7);
        i_valid = 1'b1; i_data = IW'(1);
        i_bias = AW'(3); i_shift = '0; i_relu_en = 1'b0;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      vectors++;
      if (o_valid !== (c == 5 || c == 9)) begin
        errors++;
        $display("FAIL b2b_valid c%0d: got %b, required %b",
                 c, o_valid, (c == 5 || c == 9));
      end
      @(posedge clk); #1;
    end
    check_drained("b2b");
  endtask

  task automatic test_flush;
    beat(50, 0, 0, 0);
    beat(50, 0, 0, 0);
    i_flush = 1'b1;
    beat(50, 0, 0, 0);
    i_flush = 1'b0;
    vectors++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got %b, required 0", o_busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(8'd40);
      beat(10, 0, 0, 0);
    end
    idle(4);
    // a flush right after the last beat kills the pending result
    for (int i = 0; i < 4; i++) beat(7, 0, 0, 0);
    i_valid = 1'b0;
    i_flush = 1'b1;
    @(posedge clk); #1;
    idle(4);
    beat(4, 0, 2, 0);
    beat(4, 0, 0, 0);
    beat(4, 0, 0, 0);
    exp_q.push_back(8'd4);
    beat(4, 0, 0, 0);
    idle(4);
    check_drained("flush");
  endtask

  task automatic test_mid_reset;
    beat(9, 0, 0, 0);
    beat(9, 0, 0, 0);
    i_valid = 1'b0;
    #3;
    vectors++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: got %b, required 1", o_busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({o_data, o_valid, o_busy} !== 10'b0) begin
      errors++;
      $display("FAIL midrst_clear: got data=%h valid=%b busy=%b, required 0/0/0",
               o_data, o_valid, o_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(8'd20);
      beat(5, 0, 0, 0);
    end
    idle(5);
    check_drained("midrst");
  endtask

  task automatic test_random;
    for (int g = 0; g < 8; g++) begin
      int b, s, d;
      bit rl;
      longint sum;
      b   = int'($urandom_range(0, 20000)) - 10000;
      s   = int'($urandom_range(0, 10));
      rl  = 1'($urandom_range(0, 1));
      sum = b;
      for (int i = 0; i < 4; i++) begin
        d = int'($urandom_range(0, 400000)) - 200000;
        sum += d;
        if (i == 3) exp_q.push_back(model(sum, s, rl));
        beat(d, b, s, rl);
      end
    end
    idle(5);
    check_drained("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
